// File: rtl/conv1x1_pkg.sv
// Shared definitions for the 1x1 convolution weight MAC.
//   acc_width : result width for a DATA_WIDTH x DATA_WIDTH dot product of
//               IN_CHANNELS terms (exact, no overflow possible).
//   state_e   : sweep FSM states.
//   tag_t     : read tag carried alongside each outstanding BRAM read.
package conv1x1_pkg;

    function automatic int acc_width(input int data_width, input int in_channels);
        return 2 * data_width + $clog2(in_channels);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Channel field is sized for the largest supported OUT_CHANNELS; users
    // truncate to their own index width.
    localparam int TAG_CH_W = 8;

    typedef struct packed {
        logic [TAG_CH_W-1:0] ch;
        logic                last;
    } tag_t;

endpackage

// File: rtl/conv1x1_weight_mac_fifo.sv
// First-word-fall-through FIFO with a registered head.
//   push/din : write an entry (must not be full)
//   pop      : remove the head (ignored when empty)
//   count    : number of stored entries
//   empty/full
//   head     : registered copy of the oldest entry; holds its last value
//              once the FIFO drains, zero after reset.
module sync_fifo_fwft #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             pop_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign head   = head_q;
    assign pop_ok = pop && !empty;

    always_comb begin
        wr_ptr_d = push   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Keep the head register equal to the oldest entry: after a pop the
        // next entry comes from memory, or straight from din when the FIFO
        // would otherwise have been left with only the entry being pushed.
        head_d = head_q;
        if (pop_ok) begin
            if (count_q > CW'(1)) head_d = mem_q[rd_ptr_q + AW'(1)];
            else if (push)        head_d = din;
        end else if (empty && push) begin
            head_d = din;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // The issue credit check upstream guarantees space for every push.
    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/conv1x1_weight_mac.sv
// 1x1 convolution weight MAC.
// Latches one pixel (IN_CHANNELS signed activations), sweeps the weight BRAM
// over all OUT_CHANNELS kernels and emits one signed dot product per output
// channel, in channel order, through a credit-managed FWFT FIFO.
//   pix_*      : pixel input handshake
//   w_rd_*     : weight BRAM read port (registered address/enable)
//   out_*      : result stream with backpressure (out_last on final channel)
//   busy       : FSM active or results still queued
module conv1x1_weight_mac
    import conv1x1_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int IN_CHANNELS  = 3,
    parameter  int OUT_CHANNELS = 4,
    parameter  int RD_LATENCY   = 1,
    parameter  int FIFO_DEPTH   = 4,
    localparam int ACC_WIDTH    = acc_width(DATA_WIDTH, IN_CHANNELS),
    localparam int CH_W         = $clog2(OUT_CHANNELS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [DATA_WIDTH*IN_CHANNELS-1:0] pix_data,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    output logic [CH_W-1:0]                   w_rd_addr,
    output logic                              w_rd_en,
    input  logic [DATA_WIDTH*IN_CHANNELS-1:0] w_rd_data,
    output logic signed [ACC_WIDTH-1:0]       out_data,
    output logic [CH_W-1:0]                   out_ch,
    output logic                              out_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy
);

    localparam int IF_W = $clog2(FIFO_DEPTH + 1);
    localparam int FW   = ACC_WIDTH + CH_W + 1;

    state_e                            state_q, state_d;
    logic [DATA_WIDTH*IN_CHANNELS-1:0] pix_q, pix_d;
    logic [CH_W-1:0]                   ch_cnt_q, ch_cnt_d;
    logic [IF_W-1:0]                   inflight_q, inflight_d;
    logic                              w_rd_en_q, w_rd_en_d;
    logic [CH_W-1:0]                   w_rd_addr_q, w_rd_addr_d;
    logic [RD_LATENCY:0]               vld_pipe_q, vld_pipe_d;
    tag_t                              tag_pipe_q [RD_LATENCY+1];
    tag_t                              tag_pipe_d [RD_LATENCY+1];

    logic                        issue;
    logic                        push;
    logic                        fifo_empty, fifo_full;
    logic [IF_W-1:0]             fifo_count;
    logic signed [ACC_WIDTH-1:0] dot;
    logic [FW-1:0]               fifo_din, fifo_head;
    tag_t                        ret_tag;

    // Stage 0 of the tag line is registered together with w_rd_en, so the
    // tag reaches stage RD_LATENCY exactly when the BRAM data is valid.
    assign push    = vld_pipe_q[RD_LATENCY];
    assign ret_tag = tag_pipe_q[RD_LATENCY];

    always_comb begin
        state_d     = state_q;
        pix_d       = pix_q;
        ch_cnt_d    = ch_cnt_q;
        w_rd_en_d   = 1'b0;
        w_rd_addr_d = w_rd_addr_q;
        issue       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pix_valid) begin
                    pix_d    = pix_data;
                    ch_cnt_d = '0;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                // Credit check on registered values: every outstanding read
                // already owns a FIFO slot, so a push can never hit full.
                if ((int'(fifo_count) + int'(inflight_q)) < FIFO_DEPTH) begin
                    issue       = 1'b1;
                    w_rd_en_d   = 1'b1;
                    w_rd_addr_d = ch_cnt_q;
                    ch_cnt_d    = ch_cnt_q + CH_W'(1);
                    if (ch_cnt_q == CH_W'(OUT_CHANNELS - 1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        case ({issue, push})
            2'b10:   inflight_d = inflight_q + IF_W'(1);
            2'b01:   inflight_d = inflight_q - IF_W'(1);
            default: inflight_d = inflight_q;
        endcase
        vld_pipe_d         = {vld_pipe_q[RD_LATENCY-1:0], issue};
        tag_pipe_d[0].ch   = TAG_CH_W'(ch_cnt_q);
        tag_pipe_d[0].last = (ch_cnt_q == CH_W'(OUT_CHANNELS - 1));
        for (int i = 1; i <= RD_LATENCY; i++) tag_pipe_d[i] = tag_pipe_q[i-1];
    end

    always_comb begin
        dot = '0;
        for (int k = 0; k < IN_CHANNELS; k++) begin
            logic signed [DATA_WIDTH-1:0]   a, b;
            logic signed [2*DATA_WIDTH-1:0] p;
            a   = pix_q[k*DATA_WIDTH +: DATA_WIDTH];
            b   = w_rd_data[k*DATA_WIDTH +: DATA_WIDTH];
            p   = a * b;
            dot = dot + ACC_WIDTH'(p);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pix_q       <= '0;
            ch_cnt_q    <= '0;
            inflight_q  <= '0;
            w_rd_en_q   <= 1'b0;
            w_rd_addr_q <= '0;
            vld_pipe_q  <= '0;
            for (int i = 0; i <= RD_LATENCY; i++) tag_pipe_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            pix_q       <= pix_d;
            ch_cnt_q    <= ch_cnt_d;
            inflight_q  <= inflight_d;
            w_rd_en_q   <= w_rd_en_d;
            w_rd_addr_q <= w_rd_addr_d;
            vld_pipe_q  <= vld_pipe_d;
            for (int i = 0; i <= RD_LATENCY; i++) tag_pipe_q[i] <= tag_pipe_d[i];
        end
    end

    assign fifo_din = {dot, CH_W'(ret_tag.ch), ret_tag.last};

    sync_fifo_fwft #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (fifo_din),
        .pop   (out_valid && out_ready),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full),
        .head  (fifo_head)
    );

    assign out_data  = fifo_head[FW-1 -: ACC_WIDTH];
    assign out_ch    = fifo_head[CH_W:1];
    assign out_last  = fifo_head[0];
    assign out_valid = !fifo_empty;
    assign pix_ready = (state_q == IDLE) && !rst;
    assign w_rd_en   = w_rd_en_q;
    assign w_rd_addr = w_rd_addr_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_conv1x1_weight_mac.sv
// Bench: two DUTs (RD_LATENCY 1 and 2) on behavioural weight BRAMs preloaded
// with kernels ch c = [10c+10, 10c+11, 10c+12]. A scoreboard queues the four
// expected dot products at every pixel handshake and checks each pop.
module tb_conv1x1_weight_mac;
    localparam int DW = 8, IC = 3, OC = 4, FD = 4, AW = 18, CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]               pv, pr, wen, ov, olast, ordy, busy;
    logic [1:0][IC*DW-1:0]    pd;
    logic [IC*DW-1:0]         wdata0, wdata1, b2_r1;
    logic [1:0][CW-1:0]       waddr, och;
    logic [1:0][AW-1:0]       od;

    conv1x1_weight_mac #(.DATA_WIDTH(DW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC),
                         .RD_LATENCY(1), .FIFO_DEPTH(FD)) dut0 (
        .clk(clk), .rst(rst), .pix_data(pd[0]), .pix_valid(pv[0]), .pix_ready(pr[0]),
        .w_rd_addr(waddr[0]), .w_rd_en(wen[0]), .w_rd_data(wdata0),
        .out_data(od[0]), .out_ch(och[0]), .out_last(olast[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .busy(busy[0]));

    conv1x1_weight_mac #(.DATA_WIDTH(DW), .IN_CHANNELS(IC), .OUT_CHANNELS(OC),
                         .RD_LATENCY(2), .FIFO_DEPTH(FD)) dut1 (
        .clk(clk), .rst(rst), .pix_data(pd[1]), .pix_valid(pv[1]), .pix_ready(pr[1]),
        .w_rd_addr(waddr[1]), .w_rd_en(wen[1]), .w_rd_data(wdata1),
        .out_data(od[1]), .out_ch(och[1]), .out_last(olast[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .busy(busy[1]));

    function automatic int wgt(int ch, int k);
        return 10 * (ch + 1) + k;
    endfunction

    function automatic logic [IC*DW-1:0] kern(logic [CW-1:0] ch);
        logic [IC*DW-1:0] v;
        for (int k = 0; k < IC; k++) v[k*DW +: DW] = DW'(wgt(int'(ch), k));
        return v;
    endfunction

    // BRAM models: plain read for latency 1, extra output register for 2.
    always @(posedge clk) if (wen[0]) wdata0 <= kern(waddr[0]);
    always @(posedge clk) begin
        if (wen[1]) b2_r1 <= kern(waddr[1]);
        wdata1 <= b2_r1;
    end

    typedef struct { int d; int ch; bit last; } exp_t;
    exp_t exp_q [2][$];
    int   obs[$];
    int   checks = 0, errors = 0, rd_cnt0 = 0;

    task automatic check(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    // Scoreboard: handshakes queue expectations, pops are compared.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                exp_q[d].delete();
            end else begin
                if (ov[d] && ordy[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check("spurious_pop", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q[d].pop_front();
                        check("out_data", int'($signed(od[d])), e.d);
                        check("out_ch", int'(och[d]), e.ch);
                        check("out_last", int'(olast[d]), int'(e.last));
                    end
                    if (d == 0) obs.push_back(int'($signed(od[0])));
                end
                if (pv[d] && pr[d]) begin
                    for (int c = 0; c < OC; c++) begin
                        exp_t e;
                        e.d = 0;
                        for (int k = 0; k < IC; k++)
                            e.d += int'($signed(pd[d][k*DW +: DW])) * wgt(c, k);
                        e.ch   = c;
                        e.last = (c == OC - 1);
                        exp_q[d].push_back(e);
                    end
                end
            end
        end
        if (!rst && wen[0]) rd_cnt0++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a pixel, wait for the handshake, then count cycles until out_valid.
    task automatic send(input int d, input int a0, input int a1, input int a2,
                        input bit hold, output int lat);
        int n = 0;
        pd[d] = {DW'(a2), DW'(a1), DW'(a0)};
        pv[d] = 1'b1;
        while (!pr[d] && n < 50) begin tick(); n++; end
        if (n >= 50) check("pix_ready_timeout", 1, 0);
        @(posedge clk);
        #1;
        if (!hold) pv[d] = 1'b0;
        lat = 0;
        while (lat < 30) begin
            @(negedge clk);
            if (ov[d]) break;
            lat++;
        end
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        do begin @(negedge clk); n++; end
        while ((busy[d] || exp_q[d].size() != 0) && n < 200);
        if (n >= 200) check("idle_timeout", 1, 0);
        tick();
    endtask

    task automatic check_obs(input string name, input int e0, input int e1,
                             input int e2, input int e3);
        int ev[4];
        ev = '{e0, e1, e2, e3};
        check({name, "_count"}, obs.size(), 4);
        for (int i = 0; i < 4 && i < obs.size(); i++) check(name, obs[i], ev[i]);
        obs.delete();
    endtask

    initial begin
        int lat, n, k;
        pv = '0; pd = '0; ordy = 2'b11;
        #2;
        check("rst_pix_ready", int'(pr[0]), 0);
        check("rst_w_rd_en", int'(wen[0]), 0);
        check("rst_w_rd_addr", int'(waddr[0]), 0);
        check("rst_out_valid", int'(ov[0]), 0);
        check("rst_out_data", int'(od[0]), 0);
        check("rst_out_ch", int'(och[0]), 0);
        check("rst_out_last", int'(olast[0]), 0);
        check("rst_busy", int'(busy[0]), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        check("idle_pix_ready", int'(pr[0]), 1);

        // 1: basic, latency 1
        obs.delete();
        send(0, 1, 2, 3, 1'b0, lat);
        check("lat_rl1", lat, 3);
        wait_idle(0);
        check_obs("t1", 68, 128, 188, 248);

        // 2: latency 2 instance
        send(1, 1, 2, 3, 1'b0, lat);
        check("lat_rl2", lat, 4);
        wait_idle(1);

        // 3: signed activations
        send(0, -1, 0, -2, 1'b0, lat);
        wait_idle(0);
        check_obs("t3", -34, -64, -94, -124);

        // 4: backpressure for 12 cycles after the handshake
        ordy[0] = 1'b0;
        rd_cnt0 = 0;
        send(0, 1, 2, 3, 1'b0, lat);
        repeat (11 - lat) @(negedge clk);
        check("bp_out_valid", int'(ov[0]), 1);
        check("bp_out_data", int'($signed(od[0])), 68);
        check("bp_reads_le_depth", int'(rd_cnt0 <= FD), 1);
        tick();
        ordy[0] = 1'b1;
        wait_idle(0);
        check_obs("t4", 68, 128, 188, 248);

        // 5: back-to-back pixels with pix_valid held
        send(0, 1, 2, 3, 1'b1, lat);
        pd[0] = {8'sd1, 8'sd1, 8'sd1};
        n = 0;
        while (!pr[0] && n < 50) begin tick(); n++; end
        @(posedge clk);
        #1;
        pv[0] = 1'b0;
        @(negedge clk);
        check("b2b_taken", int'(pr[0]), 0);
        wait_idle(0);
        check("b2b_count", obs.size(), 8);
        if (obs.size() == 8) begin
            int ev[8];
            ev = '{68, 128, 188, 248, 33, 63, 93, 123};
            for (int i = 0; i < 8; i++) check("t5", obs[i], ev[i]);
        end
        obs.delete();

        // 6: reset after two reads
        pd[0] = {8'sd3, 8'sd2, 8'sd1};
        pv[0] = 1'b1;
        n = 0;
        while (!pr[0] && n < 50) begin tick(); n++; end
        @(posedge clk);
        #1;
        pv[0] = 1'b0;
        n = 0; k = 0;
        while (k < 2 && n < 20) begin
            @(negedge clk);
            if (wen[0]) k++;
            n++;
        end
        check("reads_before_rst", k, 2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", int'(ov[0]), 0);
        check("mid_rst_w_rd_en", int'(wen[0]), 0);
        check("mid_rst_busy", int'(busy[0]), 0);
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pix_ready", int'(pr[0]), 1);
        obs.delete();
        send(0, 1, 2, 3, 1'b0, lat);
        wait_idle(0);
        check_obs("t6", 68, 128, 188, 248);

        check("leftover_q0", exp_q[0].size(), 0);
        check("leftover_q1", exp_q[1].size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, expected completion");
        $fatal(1, "timeout");
    end
endmodule
